// File: rtl/r16_rom_const_fetch_if.sv
// Bundle between the constant-ROM fetch sequencer and its neighbours (control, ROM bank, delay pipe).
// Latency: none, wires only.
// Backpressure: stall travels master-ward; there is no ready on the constant outputs.
interface r16_rom_const_fetch_if #(
  parameter int P_WIDTH  = 64,
  parameter int SD_WIDTH = 128,
  parameter int IDX_W    = 10,
  parameter int STAGE_W  = 2
);
  logic                       start;
  logic [STAGE_W-1:0]         stage_sel;
  logic                       stall;
  logic                       busy;

  logic                       rom_rd_en;
  logic [STAGE_W+IDX_W-1:0]   rom_addr;
  logic [P_WIDTH-1:0]         ROM0_data;
  logic [SD_WIDTH-1:0]        ROM1_data, ROM2_data, ROM3_data, ROM4_data;
  logic [SD_WIDTH-1:0]        ROM5_data, ROM6_data, ROM7_data;

  logic [P_WIDTH-1:0]         ROM0_const_out;
  logic [SD_WIDTH-1:0]        ROM1_const_out, ROM2_const_out, ROM3_const_out, ROM4_const_out;
  logic [SD_WIDTH-1:0]        ROM5_const_out, ROM6_const_out, ROM7_const_out;
  logic                       const_valid;
  logic                       const_last;

  // Fetch sequencer side.
  modport master (
    input  start, stage_sel, stall,
    input  ROM0_data, ROM1_data, ROM2_data, ROM3_data, ROM4_data, ROM5_data, ROM6_data, ROM7_data,
    output busy, rom_rd_en, rom_addr,
    output ROM0_const_out, ROM1_const_out, ROM2_const_out, ROM3_const_out,
    output ROM4_const_out, ROM5_const_out, ROM6_const_out, ROM7_const_out,
    output const_valid, const_last
  );

  // Controller / ROM bank / delay-pipe side.
  modport slave (
    output start, stage_sel, stall,
    output ROM0_data, ROM1_data, ROM2_data, ROM3_data, ROM4_data, ROM5_data, ROM6_data, ROM7_data,
    input  busy, rom_rd_en, rom_addr,
    input  ROM0_const_out, ROM1_const_out, ROM2_const_out, ROM3_const_out,
    input  ROM4_const_out, ROM5_const_out, ROM6_const_out, ROM7_const_out,
    input  const_valid, const_last
  );
endinterface

// File: rtl/r16_rom_const_fetch.sv
// Sequences one FFT stage of reads from eight synchronous constant ROMs and registers the words.
// Latency: start edge E0 -> rom_rd_en after E1 -> const_valid after E3; one entry per cycle unstalled.
// Backpressure: stall pauses address issue only; reads in flight still drain. Macro CONST_ZERO_IDLE_EN zeroes outputs in non-valid cycles.
module r16_rom_const_fetch #(
  parameter int P_WIDTH     = 64,
  parameter int SD_WIDTH    = 128,
  parameter int IDX_W       = 10,
  parameter int NUM_ENTRIES = 1024,
  parameter int STAGE_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  r16_rom_const_fetch_if.master bus
);
  localparam int AW = STAGE_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [STAGE_W-1:0]           stage_q, stage_d;
  logic                         busy_q, busy_d;
  logic                         rd_en_q, rd_en_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic                         rd_last_q, rd_last_d;
  logic                         rd_d1_q, rd_d1_d;
  logic                         last_d1_q, last_d1_d;
  logic                         cvalid_q, cvalid_d;
  logic                         clast_q, clast_d;
  logic [P_WIDTH-1:0]           c0_q, c0_d;
  logic [7:1][SD_WIDTH-1:0]     csd_q, csd_d;
  logic [7:1][SD_WIDTH-1:0]     rom_sd;
  logic                         last_idx;

  assign rom_sd   = {bus.ROM7_data, bus.ROM6_data, bus.ROM5_data, bus.ROM4_data,
                     bus.ROM3_data, bus.ROM2_data, bus.ROM1_data};
  assign last_idx = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave FETCH once the final address goes out, leave DRAIN on the const_last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)                state_d = S_FETCH;
      S_FETCH: if (!bus.stall && last_idx)   state_d = S_DRAIN;
      S_DRAIN: if (clast_q)                  state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Outputs: address issue per state, then the fixed two-stage return pipe with the last tag riding along.
  always_comb begin
    idx_d     = idx_q;
    stage_d   = stage_q;
    busy_d    = busy_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    rd_last_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          stage_d = bus.stage_sel;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (!bus.stall) begin
          rd_en_d   = 1'b1;
          addr_d    = {stage_q, idx_q};
          rd_last_d = last_idx;
          // Hold at the last index so idx never wraps inside a stage.
          if (!last_idx) idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (clast_q) busy_d = 1'b0;
      end
      default: ;
    endcase

    rd_d1_d   = rd_en_q;
    last_d1_d = rd_last_q;
    cvalid_d  = rd_d1_q;
    clast_d   = rd_d1_q & last_d1_q;
    if (rd_d1_q) begin
      c0_d  = bus.ROM0_data;
      csd_d = rom_sd;
    end else begin
`ifdef CONST_ZERO_IDLE_EN
      c0_d  = '0;
      csd_d = '0;
`else
      c0_d  = c0_q;
      csd_d = csd_q;
`endif
    end
  end

  // Datapath and control registers; everything clears on reset so no partial fetch survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      stage_q   <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      rd_last_q <= 1'b0;
      rd_d1_q   <= 1'b0;
      last_d1_q <= 1'b0;
      cvalid_q  <= 1'b0;
      clast_q   <= 1'b0;
      c0_q      <= '0;
      csd_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      rd_last_q <= rd_last_d;
      rd_d1_q   <= rd_d1_d;
      last_d1_q <= last_d1_d;
      cvalid_q  <= cvalid_d;
      clast_q   <= clast_d;
      c0_q      <= c0_d;
      csd_q     <= csd_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.rom_rd_en      = rd_en_q;
  assign bus.rom_addr       = addr_q;
  assign bus.const_valid    = cvalid_q;
  assign bus.const_last     = clast_q;
  assign bus.ROM0_const_out = c0_q;
  assign bus.ROM1_const_out = csd_q[1];
  assign bus.ROM2_const_out = csd_q[2];
  assign bus.ROM3_const_out = csd_q[3];
  assign bus.ROM4_const_out = csd_q[4];
  assign bus.ROM5_const_out = csd_q[5];
  assign bus.ROM6_const_out = csd_q[6];
  assign bus.ROM7_const_out = csd_q[7];
endmodule

// File: tb/tb_r16_rom_const_fetch.sv
// Bench for r16_rom_const_fetch with a four-entry stage and a synchronous ROM model.
// Latency: checks cycle-exact timing from a vector table, then random stall/start traffic.
// Backpressure: stall driven randomly; spurious starts while busy must be ignored.
module tb_r16_rom_const_fetch;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  r16_rom_const_fetch_if #(.P_WIDTH(64), .SD_WIDTH(128), .IDX_W(10), .STAGE_W(2)) ifc ();

  r16_rom_const_fetch #(
    .P_WIDTH(64), .SD_WIDTH(128), .IDX_W(10), .NUM_ENTRIES(N), .STAGE_W(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  // ROM k returns a word tagged with its own number so cross-wired buses show up.
  function automatic logic [127:0] rom_word(input int k, input logic [11:0] a);
    return {32'(k), 32'h5A5A_0000, 52'h0, a};
  endfunction

  // Synchronous ROM bank: data appears the cycle after rom_rd_en.
  always @(posedge clk) begin
    if (ifc.rom_rd_en) begin
      ifc.ROM0_data <= 64'(ifc.rom_addr);
      ifc.ROM1_data <= rom_word(1, ifc.rom_addr);
      ifc.ROM2_data <= rom_word(2, ifc.rom_addr);
      ifc.ROM3_data <= rom_word(3, ifc.rom_addr);
      ifc.ROM4_data <= rom_word(4, ifc.rom_addr);
      ifc.ROM5_data <= rom_word(5, ifc.rom_addr);
      ifc.ROM6_data <= rom_word(6, ifc.rom_addr);
      ifc.ROM7_data <= rom_word(7, ifc.rom_addr);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic        stall;
    logic        rd;
    logic [11:0] addr;
    logic        vld;
    logic [11:0] c0;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t        vt[18];
  logic [11:0] q[$];
  logic [11:0] ea;
  logic [1:0]  s;
  logic        prev_stall;
  logic        done;
  int          nrd, issued, got, cyc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //           start sel   stall  rd    addr      vld   c0        last  busy
    vt[0]  = '{1'b1, 2'd2, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 12'h800, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 12'h801, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 1'b1, 12'h802, 1'b1, 12'h800, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 12'h803, 1'b1, 12'h801, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 12'h803, 1'b1, 12'h802, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 12'h803, 1'b1, 12'h803, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 2'd1, 1'b1, 1'b0, 12'h803, 1'b0, 12'h000, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 12'h803, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 12'hC00, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 12'hC01, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 12'hC01, 1'b1, 12'hC00, 1'b0, 1'b1};
    vt[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 12'hC01, 1'b1, 12'hC01, 1'b0, 1'b1};
    vt[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 12'hC02, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 12'hC03, 1'b0, 12'h000, 1'b0, 1'b1};
    vt[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 12'hC03, 1'b1, 12'hC02, 1'b0, 1'b1};
    vt[16] = '{1'b0, 2'd0, 1'b0, 1'b0, 12'hC03, 1'b1, 12'hC03, 1'b1, 1'b1};
    vt[17] = '{1'b0, 2'd0, 1'b1, 1'b0, 12'hC03, 1'b0, 12'h000, 1'b0, 1'b0};

    ifc.start     = 1'b0;
    ifc.stage_sel = 2'd0;
    ifc.stall     = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rd_en",  128'(ifc.rom_rd_en),      128'(0));
    check("reset_addr",   128'(ifc.rom_addr),       128'(0));
    check("reset_valid",  128'(ifc.const_valid),    128'(0));
    check("reset_last",   128'(ifc.const_last),     128'(0));
    check("reset_busy",   128'(ifc.busy),           128'(0));
    check("reset_c0",     128'(ifc.ROM0_const_out), 128'(0));
    check("reset_c7",     ifc.ROM7_const_out,       128'(0));
    rst_n = 1'b1;

    // Cycle-exact vectors: basic fetch, ignored starts, back-to-back stage 3 with a 2-cycle stall.
    for (int i = 0; i < 18; i++) begin
      ifc.start     = vt[i].start;
      ifc.stage_sel = vt[i].sel;
      ifc.stall     = vt[i].stall;
      @(negedge clk);
      check($sformatf("vec%0d_rd", i),   128'(ifc.rom_rd_en),   128'(vt[i].rd));
      check($sformatf("vec%0d_addr", i), 128'(ifc.rom_addr),    128'(vt[i].addr));
      check($sformatf("vec%0d_vld", i),  128'(ifc.const_valid), 128'(vt[i].vld));
      check($sformatf("vec%0d_last", i), 128'(ifc.const_last),  128'(vt[i].last));
      check($sformatf("vec%0d_busy", i), 128'(ifc.busy),        128'(vt[i].busy));
      if (vt[i].vld) begin
        check($sformatf("vec%0d_c0", i), 128'(ifc.ROM0_const_out), 128'(vt[i].c0));
        check($sformatf("vec%0d_c3", i), ifc.ROM3_const_out,       rom_word(3, vt[i].c0));
      end
    end
    ifc.start = 1'b0;
    ifc.stall = 1'b0;
`ifdef CONST_ZERO_IDLE_EN
    check("idle_c7_zero", ifc.ROM7_const_out, 128'(0));
`else
    check("idle_c7_hold", ifc.ROM7_const_out, rom_word(7, 12'hC03));
`endif

    // Reset in the middle of a stage-0 fetch, then a clean stage-1 fetch.
    ifc.start     = 1'b1;
    ifc.stage_sel = 2'd0;
    @(negedge clk);
    ifc.start = 1'b0;
    nrd = 0;
    for (int c = 0; c < 20 && nrd < 2; c++) begin
      @(negedge clk);
      if (ifc.rom_rd_en) nrd++;
    end
    check("rstmid_reads_seen", 128'(nrd), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_rd_en", 128'(ifc.rom_rd_en),      128'(0));
    check("rstmid_addr",  128'(ifc.rom_addr),       128'(0));
    check("rstmid_valid", 128'(ifc.const_valid),    128'(0));
    check("rstmid_last",  128'(ifc.const_last),     128'(0));
    check("rstmid_busy",  128'(ifc.busy),           128'(0));
    check("rstmid_c0",    128'(ifc.ROM0_const_out), 128'(0));
    check("rstmid_c7",    ifc.ROM7_const_out,       128'(0));
    @(negedge clk);
    rst_n         = 1'b1;
    ifc.start     = 1'b1;
    ifc.stage_sel = 2'd1;
    @(negedge clk);
    ifc.start = 1'b0;
    q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifc.rom_rd_en) q.push_back(ifc.rom_addr);
      if (!ifc.busy) break;
    end
    check("rstmid_addr_count", 128'(q.size()), 128'(N));
    for (int i = 0; i < N; i++)
      if (i < q.size()) check($sformatf("rstmid_seq%0d", i), 128'(q[i]), 128'(12'h400 + 12'(i)));

    // Random stages with random stalls and spurious starts, checked against the expected entry stream.
    for (int t = 0; t < 30; t++) begin
      s = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ifc.start     = 1'b1;
      ifc.stage_sel = s;
      ifc.stall     = 1'($urandom_range(0, 1));
      prev_stall    = ifc.stall;
      issued = 0; got = 0; cyc = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        cyc++;
        if (prev_stall) check("rnd_stall_rd", 128'(ifc.rom_rd_en), 128'(0));
        if (ifc.rom_rd_en) begin
          check("rnd_addr", 128'(ifc.rom_addr), 128'({s, 10'(issued)}));
          issued++;
        end
        if (ifc.const_valid) begin
          if (got >= N) begin
            check("rnd_valid_after_last", 128'(ifc.const_valid), 128'(0));
            done = 1'b1;
          end else begin
            ea = {s, 10'(got)};
            check("rnd_c0",   128'(ifc.ROM0_const_out), 128'(ea));
            check("rnd_c5",   ifc.ROM5_const_out,       rom_word(5, ea));
            check("rnd_last", 128'(ifc.const_last),     128'(got == N - 1));
            check("rnd_busy", 128'(ifc.busy),           128'(1));
            got++;
          end
        end else if (got == N) begin
          check("rnd_busy_end", 128'(ifc.busy),  128'(0));
          check("rnd_issued",   128'(issued),    128'(N));
          done = 1'b1;
        end
        if (!done && cyc > 200) begin
          check("rnd_timeout_entries", 128'(got), 128'(N));
          done = 1'b1;
        end
        ifc.start     = done ? 1'b0 : ($urandom_range(0, 3) == 0);
        ifc.stage_sel = 2'($urandom_range(0, 3));
        ifc.stall     = done ? 1'b0 : ($urandom_range(0, 2) == 0);
        prev_stall    = ifc.stall;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/r16_rom_const_fetch.md
Name: r16_rom_const_fetch

Overview:
- Upstream feeder for the radix-16 twiddle/constant pipe delay stage. Sequences reads of eight synchronous constant ROMs (ROM0: P_WIDTH; ROM1..ROM7: SD_WIDTH) for one FFT stage.
- Registers the returned words into aligned ROMx_const_out buses, with a valid/last tag.
- Its outputs connect directly to the ROMx_const_in ports of the constant delay pipe.

Parameters:
- P_WIDTH, 64, width of ROM0 constant (modulus word).
- SD_WIDTH, 128, width of ROM1..ROM7 constants.
- IDX_W, 10, entry-index width per stage.
- NUM_ENTRIES, 1024, entries per stage; must be ≤ 2^IDX_W and ≥ 2.
- STAGE_W, 2, stage-select width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to fetch one stage; honoured only when busy=0.
- stage_sel  in  STAGE_W  stage to fetch; sampled with the accepted start.
- stall  in  1  pauses address issue while high.
- rom_rd_en  out  1  registered ROM read strobe, shared by all 8 ROMs.
- rom_addr  out  STAGE_W+IDX_W  registered address {stage, idx}.
- ROM0_data  in  P_WIDTH  ROM0 read data; valid the cycle after rom_rd_en.
- ROM1_data..ROM7_data  in  SD_WIDTH each  ROM1..7 read data; same timing as ROM0_data.
- ROM0_const_out  out  P_WIDTH  registered constant.
- ROM1_const_out..ROM7_const_out  out  SD_WIDTH each  registered constants.
- const_valid  out  1  all ROMx_const_out hold a new entry this cycle.
- const_last  out  1  high with the final const_valid of the stage.
- busy  out  1  high from accepted start until after const_last.

Behaviour:
- Reset:
  - state=IDLE; idx=0; stage register=0.
  - rom_rd_en=0; rom_addr=0.
  - All ROMx_const_out=0; const_valid=0; const_last=0; busy=0.
  - Reset applies asynchronously at any time, including mid-fetch. No partial results survive. After release the block waits for a new start.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - Edge with start=1: latch stage_sel, idx←0, busy←1, go to FETCH.
  - start with busy=1 is ignored. No queueing.
- FETCH, at each edge:
  - stall=0: rom_rd_en←1, rom_addr←{stage, idx}, idx←idx+1. If idx==NUM_ENTRIES-1, go to DRAIN (the last address has been issued).
  - stall=1: rom_rd_en←0; idx and rom_addr hold.
  - stall has no effect outside FETCH.
- DRAIN:
  - rom_rd_en←0.
  - Stay until the last read has produced const_last. On the edge ending the const_last cycle: busy←0, go to IDLE.
- Data path:
  - rd_d1 = rom_rd_en delayed 1 cycle.
  - On an edge with rd_d1=1: ROMx_const_out←ROMx_data and const_valid←1. Otherwise const_valid←0.
  - const_valid is therefore rom_rd_en delayed 2 cycles.
  - Entry order equals address order. There are no gaps except those caused by stall.
- Latency:
  - start sampled at edge E0 → first rom_rd_en high during E1..E2 → first const_valid high during E3..E4.
  - Without stall, NUM_ENTRIES consecutive const_valid cycles follow.
- const_last: tag carried with the final address through the same 2-stage pipe.
- busy: high from the cycle after E0 until the edge following const_last. A start in the const_last cycle is ignored.
- rom_addr never exceeds {stage, NUM_ENTRIES-1}. idx does not wrap inside a stage.

Optional Feature:
- Macro: CONST_ZERO_IDLE_EN.
- Defined: on any edge with rd_d1=0, all ROMx_const_out←0, so downstream sees zero in non-valid cycles.
- Undefined: ROMx_const_out hold their last captured value when const_valid=0, which saves 8 wide muxes.
- const_valid and const_last behave identically in both builds.

Test Plan:
- Reset mid-fetch (NUM_ENTRIES=4): assert rst_n=0 after 2 reads → all outputs 0 immediately, busy=0. After release, start, stage_sel=1 → rom_addr sequence 0x400, 0x401, 0x402, 0x403.
- Basic fetch (NUM_ENTRIES=4, stage_sel=2, ROM returns data=address): start at E0 → rom_rd_en high E1..E5 with addr 0x800..0x803. const_valid high E3..E7, ROM0_const_out=0x800..0x803. const_last only with 0x803. busy falls after E7.
- Stall (NUM_ENTRIES=4): stall=1 for 2 cycles after the 2nd address → rom_rd_en low 2 cycles, addr holds 0x001. Outputs are 0,1,(2-cycle gap),2,3 with no loss or duplicate.
- Ignored start: pulse start at the 2nd and the const_last cycle of a running fetch → no restart, exactly NUM_ENTRIES valids. A later start with busy=0 is accepted.
- Back-to-back: start on the cycle after busy falls, stage_sel=3 → new sequence 0xC00.. begins 3 cycles later.
- Idle outputs: after the stage completes, build with CONST_ZERO_IDLE_EN → ROM7_const_out=0. Build without it → ROM7_const_out holds the final 128-bit word.
